seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered successor to the team's 4-bit combinational ALU.
- Keeps the same 8-opcode map and adds:
  - generic operand width;
  - valid/ready handshakes on input and output;
  - multi-cycle shift-add multiply and restoring divide/modulo;
  - status flags.
- Sits between an operand source (register file or test sequencer) and a result sink. One operation is in flight at a time.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32); result is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  operands and opcode valid
- in_ready  out  1  block can accept an operation
- a  in  WIDTH  operand A, unsigned
- b  in  WIDTH  operand B, unsigned
- op  in  3  opcode: 0 ADD, 1 MUL, 2 MOD, 3 AND, 4 SUB, 5 DIV, 6 OR, 7 XOR
- out_valid  out  1  result and flags valid
- out_ready  in  1  sink accepts result
- result  out  2*WIDTH  operation result
- zero  out  1  result == 0
- div_zero  out  1  DIV or MOD issued with b == 0

Behaviour:
- Reset (rst_n low at a rising edge):
  - state = IDLE; in_ready = 1; out_valid = 0; result = 0; zero = 0; div_zero = 0; counter = 0.
  - Reset wins over every other event, including mid-iteration; a partial operation is discarded and never produces out_valid.
- States:
  - IDLE:
    - in_ready = 1.
    - On in_valid, latch a, b and op.
    - Single-cycle ops (ADD, AND, SUB, OR, XOR) compute and register result/flags in the same edge -> DONE.
    - MUL, DIV and MOD load the accumulator/remainder, set counter = WIDTH -> CALC.
  - CALC:
    - in_ready = 0.
    - One shift-add (MUL) or shift-subtract (DIV/MOD) step per cycle; counter decrements.
    - On the edge where counter reaches 0, register result/flags -> DONE.
  - DONE:
    - out_valid = 1; in_ready = 0.
    - result and flags stay stable while out_ready = 0.
    - Handshake on out_valid & out_ready -> IDLE; out_valid is low on the next cycle.
- Latency, measured from the accepting edge k:
  - single-cycle ops: out_valid high after edge k.
  - MUL/DIV/MOD: out_valid high after edge k+WIDTH.
  - Minimum issue interval is 2 cycles (no overlap of DONE and IDLE).
- in_valid while in_ready = 0 is ignored; the source must hold its request.
- Arithmetic (all operands unsigned, result is 2*WIDTH bits):
  - ADD: zero-extended sum; carry lands in bit WIDTH.
  - SUB: (a - b) mod 2^(2*WIDTH), so a < b sign-fills the upper bits.
  - MUL: full 2*WIDTH-bit product.
  - DIV: quotient, zero-extended.
  - MOD: remainder, zero-extended.
  - AND/OR/XOR: zero-extended.
- Divide by zero: DIV returns a quotient of all-ones in the low WIDTH bits, upper bits 0. MOD returns a. div_zero = 1, and the full WIDTH-cycle latency is still spent.
- div_zero = 0 for all other ops. zero reflects the final registered result.
- op values are decoded fully; no default/illegal path exists.

Decomposition:
- Package alu_pkg holds:
  - a 3-bit opcode typedef with the constants OP_ADD, OP_MUL, OP_MOD, OP_AND, OP_SUB, OP_DIV, OP_OR, OP_XOR;
  - a state typedef with IDLE, CALC, DONE.
- One natural sub-module, seq_alu_muldiv:
  - holds the iterative engine: accumulator/remainder registers, the counter, and the done pulse;
  - has ports start, is_div, a, b, busy, done, product, quotient, remainder.
- The top-level seq_alu keeps the FSM, the single-cycle datapath, the flags and the handshakes.

Test Plan:
- WIDTH=8, ADD 200+100, out_ready=1 -> result 0x012C one cycle after accept, zero=0; in_ready high again the following cycle.
- SUB 3-5 -> result 0xFFFE. XOR 0xAA^0xAA -> result 0x0000, zero=1.
- MUL 255*255 -> result 0xFE01 exactly 8 cycles after the accepting edge; in_ready=0 and in_valid ignored throughout CALC.
- DIV 200/7 -> result 0x001C. MOD 200/7 -> result 0x0004. DIV 9/0 -> result 0x00FF with div_zero=1. MOD 9/0 -> result 0x0009 with div_zero=1.
- Backpressure: out_ready=0 for 5 cycles after MUL 12*13 -> out_valid and result 0x009C held stable; release -> a single handshake, then IDLE.
- rst_n low for one edge 4 cycles into DIV 100/3 -> out_valid never rises for that op; next op ADD 1+1 returns 0x0002 normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state types for the sequential ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_MUL = 3'd1,
    OP_MOD = 3'd2,
    OP_AND = 3'd3,
    OP_SUB = 3'd4,
    OP_DIV = 3'd5,
    OP_OR  = 3'd6,
    OP_XOR = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative engine: shift-add multiply and restoring divide, one bit per cycle.
module seq_alu_muldiv #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_div,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder
);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0]   r_b;
  logic               r_is_div;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;

  // Upper half is the partial product / remainder, lower half the multiplier / dividend.
  // With b == 0 every trial subtract succeeds, giving an all-ones quotient and remainder a.
  always_comb begin
    w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    w_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_ge    = w_shift >= {1'b0, r_b};
    w_diff  = w_shift - {1'b0, r_b};
    if (r_is_div) begin
      w_acc_next = {(w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};
    end else begin
      w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
      r_cnt    <= '0;
    end else if (start) begin
      r_acc    <= {{WIDTH{1'b0}}, a};
      r_b      <= b;
      r_is_div <= is_div;
      r_cnt    <= CNT_W'(WIDTH);
    end else if (r_cnt != '0) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Outputs show the value the final step will store, so the caller can register it
  // on the same edge the counter hits zero.
  assign busy      = (r_cnt != '0);
  assign done      = (r_cnt == CNT_W'(1));
  assign product   = w_acc_next;
  assign quotient  = w_acc_next[WIDTH-1:0];
  assign remainder = w_acc_next[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes; multi-cycle ops run in seq_alu_muldiv.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               zero,
  output logic               div_zero
);

  state_e             r_state;
  op_e                r_op;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [2*WIDTH-1:0] r_result;
  logic               r_zero;
  logic               r_div_zero;
  logic               r_bz;

  op_e                w_op;
  logic               w_multi;
  logic               w_start;
  logic [2*WIDTH-1:0] w_single;
  logic [2*WIDTH-1:0] w_md_res;
  logic               w_md_busy;
  logic               w_md_done;
  logic [2*WIDTH-1:0] w_product;
  logic [WIDTH-1:0]   w_quotient;
  logic [WIDTH-1:0]   w_remainder;
  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_b_ext;

  assign w_op    = op_e'(op);
  assign w_multi = (w_op == OP_MUL) || (w_op == OP_DIV) || (w_op == OP_MOD);
  assign w_start = (r_state == IDLE) && in_valid && w_multi;
  assign w_a_ext = {{WIDTH{1'b0}}, a};
  assign w_b_ext = {{WIDTH{1'b0}}, b};

  always_comb begin
    w_single = '0;
    case (w_op)
      OP_ADD: w_single = w_a_ext + w_b_ext;
      OP_SUB: w_single = w_a_ext - w_b_ext;
      OP_AND: w_single = w_a_ext & w_b_ext;
      OP_OR:  w_single = w_a_ext | w_b_ext;
      OP_XOR: w_single = w_a_ext ^ w_b_ext;
      OP_MUL: w_single = '0;
      OP_DIV: w_single = '0;
      OP_MOD: w_single = '0;
    endcase
  end

  always_comb begin
    w_md_res = w_product;
    if (r_op == OP_DIV) begin
      w_md_res = {{WIDTH{1'b0}}, w_quotient};
    end else if (r_op == OP_MOD) begin
      w_md_res = {{WIDTH{1'b0}}, w_remainder};
    end
  end

  seq_alu_muldiv #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (w_start),
    .is_div    (w_op != OP_MUL),
    .a         (a),
    .b         (b),
    .busy      (w_md_busy),
    .done      (w_md_done),
    .product   (w_product),
    .quotient  (w_quotient),
    .remainder (w_remainder)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_op        <= OP_ADD;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_div_zero  <= 1'b0;
      r_bz        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op       <= w_op;
            r_in_ready <= 1'b0;
            if (w_multi) begin
              r_bz    <= (w_op != OP_MUL) && (b == '0);
              r_state <= CALC;
            end else begin
              r_result    <= w_single;
              r_zero      <= (w_single == '0);
              r_div_zero  <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end
          end
        end
        CALC: begin
          if (w_md_busy && w_md_done) begin
            r_result    <= w_md_res;
            r_zero      <= (w_md_res == '0);
            r_div_zero  <= r_bz;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_seq_alu.sv
// Directed, table-driven bench for seq_alu at WIDTH=8.
module tb_seq_alu;

  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2:0]     op;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
  logic           zero;
  logic           div_zero;

  int n_tests = 0;
  int n_fail  = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  va;
    logic [7:0]  vb;
    logic [2:0]  vop;
    logic [15:0] exp_res;
    logic        exp_zero;
    logic        exp_dz;
    int          exp_lat;
    string       name;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one op at a negedge, count edges after the accept edge until out_valid,
  // pushing ignored junk requests while the block is busy.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] iop,
                       output int lat, output bit ready_low_ok);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_issue", longint'(in_ready), 1);
    a = ia; b = ib; op = iop; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 8'd1; b = 8'd1; op = 3'd0;
    lat = 0;
    ready_low_ok = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready) ready_low_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_ov_drop"}, longint'(out_valid), 0);
    check({name, "_ir_back"}, longint'(in_ready), 1);
  endtask

  initial begin
    int  lat;
    bit  rdy_ok;
    logic [15:0] held;
    bit  stable;
    bit  never;

    vecs[0]  = '{8'd200, 8'd100, 3'd0, 16'h012C, 1'b0, 1'b0, 0, "add_200_100"};
    vecs[1]  = '{8'd3,   8'd5,   3'd4, 16'hFFFE, 1'b0, 1'b0, 0, "sub_3_5"};
    vecs[2]  = '{8'hAA,  8'hAA,  3'd7, 16'h0000, 1'b1, 1'b0, 0, "xor_aa_aa"};
    vecs[3]  = '{8'd255, 8'd255, 3'd1, 16'hFE01, 1'b0, 1'b0, 8, "mul_255_255"};
    vecs[4]  = '{8'd200, 8'd7,   3'd5, 16'h001C, 1'b0, 1'b0, 8, "div_200_7"};
    vecs[5]  = '{8'd200, 8'd7,   3'd2, 16'h0004, 1'b0, 1'b0, 8, "mod_200_7"};
    vecs[6]  = '{8'd9,   8'd0,   3'd5, 16'h00FF, 1'b0, 1'b1, 8, "div_9_0"};
    vecs[7]  = '{8'd9,   8'd0,   3'd2, 16'h0009, 1'b0, 1'b1, 8, "mod_9_0"};
    vecs[8]  = '{8'hF0,  8'h3C,  3'd3, 16'h0030, 1'b0, 1'b0, 0, "and_f0_3c"};
    vecs[9]  = '{8'hF0,  8'h0F,  3'd6, 16'h00FF, 1'b0, 1'b0, 0, "or_f0_0f"};
    vecs[10] = '{8'd255, 8'd1,   3'd0, 16'h0100, 1'b0, 1'b0, 0, "add_carry"};
    vecs[11] = '{8'd0,   8'd5,   3'd1, 16'h0000, 1'b1, 1'b0, 8, "mul_0_5"};
    vecs[12] = '{8'd7,   8'd200, 3'd5, 16'h0000, 1'b1, 1'b0, 8, "div_7_200"};
    vecs[13] = '{8'd7,   8'd200, 3'd2, 16'h0007, 1'b0, 1'b0, 8, "mod_7_200"};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_result", longint'(result), 0);
    check("rst_zero", longint'(zero), 0);
    check("rst_div_zero", longint'(div_zero), 0);

    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].va, vecs[i].vb, vecs[i].vop, lat, rdy_ok);
      check({vecs[i].name, "_latency"}, longint'(lat), longint'(vecs[i].exp_lat));
      check({vecs[i].name, "_result"}, longint'(result), longint'(vecs[i].exp_res));
      check({vecs[i].name, "_zero"}, longint'(zero), longint'(vecs[i].exp_zero));
      check({vecs[i].name, "_div_zero"}, longint'(div_zero), longint'(vecs[i].exp_dz));
      if (vecs[i].exp_lat > 0) check({vecs[i].name, "_busy_ready"}, longint'(rdy_ok), 1);
      handshake(vecs[i].name);
    end

    // Backpressure: result must hold while the sink stalls, then exactly one handshake.
    issue(8'd12, 8'd13, 3'd1, lat, rdy_ok);
    check("bp_result", longint'(result), 16'h009C);
    held = result;
    stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (!out_valid || result != held || in_ready) stable = 1'b0;
    end
    check("bp_stable", longint'(stable), 1);
    handshake("bp");
    never = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid || !in_ready) never = 1'b0;
    end
    check("bp_single_handshake", longint'(never), 1);

    // Reset 4 cycles into a divide discards it.
    a = 8'd100; b = 8'd3; op = 3'd5; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_in_ready", longint'(in_ready), 1);
    check("midrst_result", longint'(result), 0);
    never = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) never = 1'b0;
      @(negedge clk);
    end
    check("midrst_no_out_valid", longint'(never), 1);
    issue(8'd1, 8'd1, 3'd0, lat, rdy_ok);
    check("post_rst_add_lat", longint'(lat), 0);
    check("post_rst_add_result", longint'(result), 16'h0002);
    handshake("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
